// File: rtl/approx_mul_pkg.sv
// Shared types and elaboration-time helpers for the pipelined approximate multiplier.
package approx_mul_pkg;

  localparam int MAX_W = 16;
  localparam int MAX_P = 2 * MAX_W;

  // Carry-save rows between stages; the last stage carries the product in s.
  typedef struct packed {
    logic [MAX_P-1:0] s;
    logic [MAX_P-1:0] c;
    logic             exact;
  } stage_t;

  // 1 when partial product a[i]&b[j] carries negative weight.
  function automatic logic pp_neg(input int i, input int j, input int width, input int signed_m);
    return (signed_m != 0) && ((i == width - 1) != (j == width - 1));
  endfunction

  // Keeps product columns [2*width-1:trunc].
  function automatic logic [MAX_P-1:0] mask(input int trunc, input int width);
    logic [MAX_P-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_P; k++)
      if (k >= trunc && k < 2 * width) m[k] = 1'b1;
    return m;
  endfunction

  // Baugh-Wooley: -p*2^k == (~p)*2^k - 2^k, so all the -2^k terms fold into one constant.
  // Negative columns sit at weight >= width-1 > trunc, so they are never truncated.
  function automatic logic [MAX_P-1:0] bw_const(input int width, input int signed_m);
    logic [MAX_P-1:0] acc;
    acc = '0;
    for (int i = 0; i < width; i++)
      for (int j = 0; j < width; j++)
        if (pp_neg(i, j, width, signed_m)) acc = acc + (MAX_P'(1) << (i + j));
    return MAX_P'(0) - acc;
  endfunction

  function automatic bit params_ok(input int width, input int trunc, input int signed_m,
                                   input int stages);
    return (width >= 4) && (width <= MAX_W) && (trunc >= 0) && (trunc <= width - 2) &&
           (signed_m == 0 || signed_m == 1) && (stages >= 1) && (stages <= 4);
  endfunction

endpackage

// File: rtl/approx_mul_slice.sv
// One elastic register slice: loads when empty or when its contents leave this cycle.
module approx_mul_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined Baugh-Wooley multiplier with per-transaction exact/column-truncated mode.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 3,
  parameter int SIGNED = 1,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_exact,
  output logic [15:0]        txn_count
);

  localparam int               PW   = 2 * WIDTH;
  localparam int               SW   = $bits(stage_t);
  localparam logic [MAX_P-1:0] BW_K = bw_const(WIDTH, SIGNED);
  localparam logic [MAX_P-1:0] MASK = mask(TRUNC, WIDTH);

  if (!params_ok(WIDTH, TRUNC, SIGNED, STAGES)) begin : g_param_chk
    $fatal(1, "approx_mul_pipe: illegal WIDTH/TRUNC/SIGNED/STAGES");
  end

  function automatic stage_t finalize(input stage_t x);
    stage_t y;
    y.s     = x.s + x.c;
    if (!x.exact) y.s = y.s & MASK;
    y.c     = '0;
    y.exact = x.exact;
    return y;
  endfunction

  // Stage-0 datapath: partial-product rows folded into sum/carry rows by a 3:2 chain.
  stage_t w_cs;
  always_comb begin
    logic [MAX_P-1:0] s, c, row, cy;
    s   = BW_K;
    c   = '0;
    row = '0;
    cy  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      row = '0;
      for (int i = 0; i < WIDTH; i++)
        if (in_exact || (i + j) >= TRUNC)
          row[i+j] = (in_a[i] & in_b[j]) ^ pp_neg(i, j, WIDTH, SIGNED);
      cy = (s & c) | (s & row) | (c & row);
      s  = s ^ c ^ row;
      c  = cy << 1;
    end
    w_cs.s     = s;
    w_cs.c     = c;
    w_cs.exact = in_exact;
  end

  stage_t [STAGES-1:0] w_d, w_q;
  logic   [STAGES:0]   w_vld_pipe, w_rdy_pipe;

  assign w_vld_pipe[0]      = in_valid;
  assign in_ready           = w_rdy_pipe[0];
  assign w_rdy_pipe[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0 && STAGES == 1) begin : g_only
      assign w_d[k] = finalize(w_cs);
    end else if (k == 0) begin : g_first
      assign w_d[k] = w_cs;
    end else if (k == STAGES - 1) begin : g_last
      assign w_d[k] = finalize(w_q[k-1]);
    end else begin : g_mid
      assign w_d[k] = w_q[k-1];
    end

    approx_mul_slice #(.DW(SW)) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_vld_pipe[k]),
      .o_ready (w_rdy_pipe[k]),
      .i_data  (w_d[k]),
      .o_valid (w_vld_pipe[k+1]),
      .i_ready (w_rdy_pipe[k+1]),
      .o_data  (w_q[k])
    );
  end

  assign out_valid = w_vld_pipe[STAGES];
  assign out_p     = w_q[STAGES-1].s[PW-1:0];
  assign out_exact = w_q[STAGES-1].exact;

  // Carry row and product bits above 2*WIDTH of the last stage are always dropped.
  logic w_unused;
  assign w_unused = ^{w_q[STAGES-1].c, w_q[STAGES-1].s};

  logic [15:0] r_txn_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_txn_count <= '0;
    else if (out_valid && out_ready) r_txn_count <= r_txn_count + 16'd1;
  end
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe (WIDTH=8, TRUNC=3, SIGNED=1, STAGES=2).
module tb_approx_mul_pipe;

  localparam int W      = 8;
  localparam int TRUNC  = 3;
  localparam int SIGNED = 1;
  localparam int STAGES = 2;
  localparam int PW     = 2 * W;

  typedef struct {
    logic [PW-1:0] p;
    logic [PW-1:0] px;
    logic          ex;
    int            t;
    bit            lat;
  } sb_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_exact = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          bp_en = 1'b0, ordy_man = 1'b1, ordy_rnd = 1'b1;
  logic          in_ready, out_valid, out_exact, out_ready;
  logic [PW-1:0] out_p;
  logic [15:0]   txn_count;

  int  checks = 0, errors = 0, cyc = 0, n_acc = 0;
  sb_t sb_q[$];

  assign out_ready = bp_en ? ordy_rnd : ordy_man;

  approx_mul_pipe #(.WIDTH(W), .TRUNC(TRUNC), .SIGNED(SIGNED), .STAGES(STAGES)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_exact (out_exact),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ordy_rnd <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Golden: signed sum of kept partial products, straight from the definition.
  function automatic logic [PW-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ex);
    longint acc;
    logic [63:0] u;
    acc = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (ex || (i + j) >= TRUNC)) begin
          if (SIGNED != 0 && ((i == W - 1) != (j == W - 1))) acc -= (longint'(1) << (i + j));
          else                                                 acc += (longint'(1) << (i + j));
        end
    u = 64'(acc);
    return u[PW-1:0];
  endfunction

  function automatic int err_bound();
    int s;
    s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if ((i + j) < TRUNC) s += (1 << (i + j));
    return s;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ex,
                      input logic [PW-1:0] exp_p, input bit lat, output int waited);
    sb_t e;
    in_a = a; in_b = b; in_exact = ex; in_valid = 1'b1; waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 1);
    else begin
      e.p = exp_p; e.px = golden(a, b, 1'b1); e.ex = ex; e.t = cyc; e.lat = lat;
      sb_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    sb_t e;
    logic [PW-1:0] d;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 0);
      else begin
        e = sb_q.pop_front();
        chk("out_p", {16'd0, out_p}, {16'd0, e.p});
        chk("out_exact", {31'd0, out_exact}, {31'd0, e.ex});
        if (!e.ex) begin
          d = e.px - out_p;
          chk("err_bound", {31'd0, (int'(d) <= err_bound())}, 1);
        end
        if (e.lat) chk("latency", cyc - e.t, STAGES);
      end
    end
  end

  initial begin
    int w;
    logic [W-1:0] a, b;
    logic ex;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_p", {16'd0, out_p}, 0);
    chk("rst_out_exact", {31'd0, out_exact}, 0);
    chk("rst_txn_count", {16'd0, txn_count}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Directed corner products, both modes.
    send(8'd7,   8'd7,   1'b0, 16'h0020, 1'b1, w);
    send(8'd7,   8'd7,   1'b1, 16'h0031, 1'b0, w);
    send(8'hFF,  8'hFF,  1'b0, 16'hFFF0, 1'b0, w);
    send(8'hFF,  8'hFF,  1'b1, 16'h0001, 1'b0, w);
    send(8'h80,  8'h80,  1'b0, 16'h4000, 1'b0, w);
    send(8'h80,  8'h80,  1'b1, 16'h4000, 1'b0, w);
    drain();
    chk("txn_directed", {16'd0, txn_count}, n_acc);

    // Full-rate burst: accept and retire together, never a bubble.
    for (int k = 0; k < 10; k++) begin
      a = W'($urandom); b = W'($urandom); ex = 1'(k);
      send(a, b, ex, golden(a, b, ex), 1'b0, w);
      chk("no_bubble", w, 0);
    end
    drain();

    // Back-pressure: two fill the pipe, the third stalls while the head holds.
    ordy_man = 1'b0;
    send(8'd3,   8'd5,   1'b1, golden(8'd3, 8'd5, 1'b1), 1'b0, w);
    send(8'd100, 8'hF6,  1'b0, golden(8'd100, 8'hF6, 1'b0), 1'b0, w);
    in_a = 8'd77; in_b = 8'd9; in_exact = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_hold_p", {16'd0, out_p}, {16'd0, golden(8'd3, 8'd5, 1'b1)});
      chk("bp_hold_exact", {31'd0, out_exact}, 1);
    end
    @(posedge clk); #1 ordy_man = 1'b1;
    send(8'd77,  8'd9,   1'b1, golden(8'd77, 8'd9, 1'b1), 1'b0, w);
    send(8'h81,  8'd127, 1'b0, golden(8'h81, 8'd127, 1'b0), 1'b0, w);
    drain();
    chk("txn_bp", {16'd0, txn_count}, n_acc);

    // Reset with two in flight: everything dropped, count cleared at once.
    ordy_man = 1'b0;
    send(8'd12,  8'd34,  1'b0, golden(8'd12, 8'd34, 1'b0), 1'b0, w);
    send(8'd56,  8'd78,  1'b1, golden(8'd56, 8'd78, 1'b1), 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 0);
    chk("rst_mid_txn", {16'd0, txn_count}, 0);
    sb_q.delete();
    n_acc = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    ordy_man = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_stale", {31'd0, out_valid}, 0);
    end
    @(posedge clk); #1;
    send(8'hC3,  8'h5A,  1'b0, golden(8'hC3, 8'h5A, 1'b0), 1'b1, w);
    drain();
    chk("txn_after_rst", {16'd0, txn_count}, n_acc);

    // Random mixed-mode stream with stalls on both sides.
    bp_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      a = W'($urandom); b = W'($urandom); ex = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 8'h80;
        1: b = 8'h80;
        2: begin a = 8'hFF; b = 8'h7F; end
        default: ;
      endcase
      send(a, b, ex, golden(a, b, ex), 1'b0, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    bp_en = 1'b0;
    drain();
    chk("txn_final", {16'd0, txn_count}, n_acc & 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined approximate multiplier. It accepts two operands, signed (Baugh-Wooley) or unsigned, over a valid/ready handshake. Each transaction selects exact or column-truncated mode, and the block returns a full-width product STAGES cycles later. It sits in the approximate-arithmetic datapath library as the clocked, back-pressurable successor to the fixed 8-bit combinational truncated multipliers, for use inside streaming MAC/filter pipelines.

## Interface
- WIDTH, 8, operand width in bits; legal range 4..16.
- TRUNC, 3, number of low product columns dropped in approximate mode; legal range 0..WIDTH-2.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- STAGES, 2, pipeline depth and latency in cycles; legal range 1..4.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_exact  in  1  1 = exact product, 0 = truncated (approximate) product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_p  out  2*WIDTH  product.
- out_exact  out  1  in_exact of the transaction currently on out_p.
- txn_count  out  16  completed output transactions, wraps modulo 2^16.

## Operation
- Partial products are pp[i][j] = a[i] & b[j], with weight 2^(i+j).
- In signed mode the sign is w[i][j] = -1 when exactly one of i, j equals WIDTH-1, otherwise +1.
- In unsigned mode w[i][j] = +1 for all terms.
- Exact mode: out_p = a*b mod 2^(2W). This is bit-identical to the true signed or unsigned product.
- Approximate mode: out_p = (sum over i+j >= TRUNC of w*pp*2^(i+j)) mod 2^(2W).
  - Bits [TRUNC-1:0] are forced to 0.
  - Dropped terms are all non-negative, so error = exact − approx lies in [0, sum_{i+j<TRUNC} 2^(i+j)].
  - TRUNC=0 makes both modes identical.
- The mode is captured per transaction and travels with it. Mixed-mode streams are legal.
- The pipeline is elastic: each stage holds a valid bit, data and the mode bit.
  - A stage loads when it is empty or when its contents advance in the same cycle.
  - in_ready = !stage0_valid || stage0_advances (combinational through the stage chain).
- Stage split, with each stage boundary registered:
  - Stage 0: partial-product generation and carry-save reduction to two rows.
  - Last stage: final carry-propagate adder and truncation mask.
  - For STAGES=1, both happen in one stage.
  - For STAGES>2, the extra stages are register slices after reduction.
- txn_count increments on every cycle with out_valid && out_ready, wrapping 0xFFFF -> 0x0000.

## Timing
- Reset (async assert, synchronous deassert is the integrator's responsibility):
  - All stage valid bits = 0, out_valid = 0, out_p = 0, out_exact = 0, txn_count = 0.
  - in_ready = 1 from the first cycle after reset.
- Latency: a transaction accepted at edge N appears on out_valid/out_p after edge N+STAGES, provided there is no back-pressure.
- Throughput: one transaction per cycle when out_ready is held at 1.
- Capacity: STAGES transactions in flight. With out_ready=0, in_ready falls once all stages are full.
- While out_valid && !out_ready, out_p and out_exact hold stable.
- Accept and retire in the same cycle on a full pipeline: legal, no bubble, in_ready stays 1.
- in_valid=0 inserts a bubble; a bubble never increments txn_count.
- Reset mid-operation drops all in-flight transactions. No partial output follows.

## Structure
- Package approx_mul_pkg holds:
  - the weight-sign function w(i,j,WIDTH,SIGNED);
  - the truncation-mask function mask(TRUNC,WIDTH);
  - a stage payload typedef {product/carry-save rows, exact bit};
  - a parameter-legality check function used in an elaboration-time assertion.
- One natural sub-module, approx_mul_slice: a single elastic register slice with valid/ready, parametrised on payload width. It is instantiated STAGES times.

## Test plan
- WIDTH=8, TRUNC=3, SIGNED=1, STAGES=2, in_exact=0, a=7, b=7 -> out_p=0x0020 two cycles after acceptance. With in_exact=1 -> 0x0031.
- Same config, a=-1, b=-1: approximate -> 0xFFF0, exact -> 0x0001. Also a=-128, b=-128: both modes -> 0x4000.
- SIGNED=0, TRUNC=0, random 10k operand pairs, both modes -> out_p equals a*b exactly. Check txn_count=10000 mod 2^16 at the end.
- Back-pressure: hold out_ready=0 and offer 4 transactions -> 2 accepted, then in_ready=0 and out_p stable. Release out_ready -> the remaining 2 are accepted and all 4 results emerge in order with their own out_exact.
- Reset pulse with 2 transactions in flight -> out_valid=0, txn_count=0 immediately. Next accepted transaction's result appears exactly STAGES cycles later.
- Sweep STAGES=1..4 and TRUNC=0..6 with random stalls on both sides -> scoreboard matches the golden sum model and the error bound holds.
